dial_position_tracker: RTL

- Stage directly downstream of line_decoder and upstream of the result accumulator in user_logic.
- Consumes one decoded rotation per line (direction and click count) and maintains the dial position modulo DIAL_CLICKS.
- Emits, per rotation, the number of times the dial pointed at 0 during that rotation.
- Uses an iterative one-full-turn-per-cycle datapath (no divider) to keep logic small at tck rates.

---
 rtl/dial_position_tracker_if.sv | 27 ++
 rtl/dial_position_tracker.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dial_position_tracker_if.sv
// Rotation-in / zero-crossing-out bundle for dial_position_tracker.
// The master modport is the upstream line decoder side; the slave modport is the tracker itself.
interface dial_position_tracker_if #(
  parameter int unsigned CLICK_BITS  = 10,
  parameter int unsigned DIAL_CLICKS = 100
);
  localparam int unsigned PosBits = $clog2(DIAL_CLICKS);

  logic                  click_valid;
  logic                  click_right_left;
  logic [CLICK_BITS-1:0] click_count;
  logic                  click_ready;
  logic                  zero_crossings_valid;
  logic [CLICK_BITS-1:0] zero_crossings_count;
  logic [PosBits-1:0]    dial_position;
  logic                  overflow_error;

  modport master (
    output click_valid, click_right_left, click_count,
    input  click_ready, zero_crossings_valid, zero_crossings_count, dial_position, overflow_error
  );

  modport slave (
    input  click_valid, click_right_left, click_count,
    output click_ready, zero_crossings_valid, zero_crossings_count, dial_position, overflow_error
  );
endinterface

// File: rtl/dial_position_tracker.sv
// Tracks dial position modulo DIAL_CLICKS and counts zero hits per rotation, one full turn per cycle.
// Define DIAL_POSITION_TRACKER_LANDING_ONLY_EN to report only whether the rotation ends on 0.
module dial_position_tracker #(
  parameter int unsigned CLICK_BITS     = 10,
  parameter int unsigned DIAL_CLICKS    = 100,
  parameter int unsigned START_POSITION = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dial_position_tracker_if.slave bus
);
  localparam int unsigned W  = CLICK_BITS + 1;
  localparam int unsigned PW = $clog2(DIAL_CLICKS);
  localparam logic [W-1:0]  Dial     = W'(DIAL_CLICKS);
  localparam logic [PW-1:0] StartPos = PW'(START_POSITION);

  typedef enum logic [1:0] {StIdle, StTurns, StFinal, StDone} state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [W-1:0]          rem_q, rem_d;
  logic [CLICK_BITS-1:0] acc_q, acc_d;
  logic [PW-1:0]         new_pos_q, new_pos_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [CLICK_BITS-1:0] zc_count_q, zc_count_d;
  logic                  zc_valid_q, zc_valid_d;
  logic                  overflow_q, overflow_d;

  logic [W-1:0]          p_ext, rem_sub, sum, diff, final_pos;
  logic                  hit;
  logic [CLICK_BITS-1:0] result;

  assign p_ext   = W'(pos_q);
  assign rem_sub = rem_q - Dial;
  assign sum     = p_ext + rem_q;
  assign diff    = p_ext - rem_q;

  // Last partial turn; rem_q < DIAL_CLICKS here, so one conditional wrap suffices.
  always_comb begin
    final_pos = '0;
    hit       = 1'b0;
    if (dir_q) begin
      if (sum >= Dial) begin
        final_pos = sum - Dial;
        hit       = 1'b1;
      end else begin
        final_pos = sum;
      end
    end else if (rem_q == '0) begin
      final_pos = p_ext;
    end else if (pos_q == '0) begin
      final_pos = Dial - rem_q;
    end else if (rem_q >= p_ext) begin
      final_pos = (rem_q == p_ext) ? diff : diff + Dial;
      hit       = 1'b1;
    end else begin
      final_pos = diff;
    end
  end

`ifdef DIAL_POSITION_TRACKER_LANDING_ONLY_EN
  assign result = (new_pos_q == '0) ? CLICK_BITS'(1) : '0;
`else
  assign result = acc_q;
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    new_pos_d  = new_pos_q;
    pos_d      = pos_q;
    zc_count_d = zc_count_q;
    zc_valid_d = 1'b0;
    // A rotation offered while busy is dropped and flagged until reset.
    overflow_d = overflow_q | (bus.click_valid & (state_q != StIdle));
    case (state_q)
      StIdle: begin
        if (bus.click_valid) begin
          dir_d   = bus.click_right_left;
          rem_d   = W'(bus.click_count);
          acc_d   = '0;
          state_d = (W'(bus.click_count) >= Dial) ? StTurns : StFinal;
        end
      end
      StTurns: begin
        rem_d   = rem_sub;
        acc_d   = acc_q + 1'b1;
        state_d = (rem_sub >= Dial) ? StTurns : StFinal;
      end
      StFinal: begin
        new_pos_d = final_pos[PW-1:0];
        if (hit) acc_d = acc_q + 1'b1;
        state_d = StDone;
      end
      StDone: begin
        pos_d      = new_pos_q;
        zc_count_d = result;
        zc_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      rem_q      <= '0;
      acc_q      <= '0;
      new_pos_q  <= StartPos;
      pos_q      <= StartPos;
      zc_count_q <= '0;
      zc_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      new_pos_q  <= new_pos_d;
      pos_q      <= pos_d;
      zc_count_q <= zc_count_d;
      zc_valid_q <= zc_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.click_ready          = (state_q == StIdle);
  assign bus.zero_crossings_valid = zc_valid_q;
  assign bus.zero_crossings_count = zc_count_q;
  assign bus.dial_position        = pos_q;
  assign bus.overflow_error       = overflow_q;
endmodule
